// File: rtl/sram_reader_pkg.sv
// Shared definitions for the SRAM record reader.
// Contents: bus/record geometry constants, word and FP16 typedefs, the
// record header layout seen on m_first words, the reader FSM state enum,
// the entry carried by the output buffer, and two address-range helpers.
package sram_reader_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 7;
  localparam int DEPTH     = 128;
  localparam int REC_WORDS = 10;
  localparam int CNT_W     = 7;
  localparam int IDX_W     = 4;
  // Wide enough for rec_count*REC_WORDS without truncation.
  localparam int TOT_W     = ADDR_W + CNT_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [15:0]       fp16_t;

  // Header word layout, msb first: x, y, z, reserved.
  typedef struct packed {
    fp16_t       x;
    fp16_t       y;
    fp16_t       z;
    logic [15:0] rsvd;
  } rec_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  // One buffered stream beat: data plus its framing.
  typedef struct packed {
    word_t            data;
    logic [IDX_W-1:0] idx;
    logic             first;
    logic             last;
    logic             rec_last;
  } skid_ent_t;

  function automatic logic [TOT_W-1:0] total_words(input logic [CNT_W-1:0] cnt);
    return TOT_W'(cnt) * TOT_W'(REC_WORDS);
  endfunction

  // True when every word of the request lies inside 0..DEPTH-1.
  function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                    input logic [CNT_W-1:0]  cnt);
    logic [TOT_W:0] sum;
    sum = (TOT_W+1)'(base) + (TOT_W+1)'(total_words(cnt));
    return sum <= (TOT_W+1)'(DEPTH);
  endfunction

endpackage

// File: rtl/sram_record_reader_if.sv
// Bus bundles for the SRAM record reader.
// sram_rd_if    : single-port SRAM read side (cen_n active low, wen active
//                 high, rdata valid one cycle after an enabled access).
//                 master = reader, slave = SRAM.
// rec_stream_if : record word stream to the compute pipeline.
//                 master = reader, slave = consumer.
interface sram_rd_if;
  import sram_reader_pkg::*;

  logic              sram_cen_n;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  word_t             sram_rdata;

  modport master (output sram_cen_n, output sram_wen, output sram_addr,
                  input  sram_rdata);
  modport slave  (input  sram_cen_n, input  sram_wen, input  sram_addr,
                  output sram_rdata);
endinterface

// Handshake: a beat transfers on every rising edge where m_valid and m_ready
// are both high. Once m_valid rises it stays high, and m_data/m_word_idx/
// m_first/m_last/m_rec_last stay stable, until that transfer happens.
// m_valid never depends on m_ready.
interface rec_stream_if;
  import sram_reader_pkg::*;

  logic             m_valid;
  logic             m_ready;
  word_t            m_data;
  logic [IDX_W-1:0] m_word_idx;
  logic             m_first;
  logic             m_last;
  logic             m_rec_last;

  modport master (output m_valid, input m_ready, output m_data,
                  output m_word_idx, output m_first, output m_last,
                  output m_rec_last);
  modport slave  (input m_valid, output m_ready, input m_data,
                  input m_word_idx, input m_first, input m_last,
                  input m_rec_last);
endinterface

// File: rtl/sram_rd_skid.sv
// Two-entry valid/ready FIFO holding framed stream beats.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_ent this cycle (caller guarantees room)
//   i_ent      : entry to write
//   i_ready    : downstream ready; a pop happens on o_valid & i_ready
//   o_valid    : head entry present
//   o_ent      : head entry
//   o_count    : occupancy 0..2, used by the caller for read credit
module sram_rd_skid
  import sram_reader_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  skid_ent_t i_ent,
  input  logic      i_ready,
  output logic      o_valid,
  output skid_ent_t o_ent,
  output logic [1:0] o_count
);

  skid_ent_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_ent   = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Push and pop together on a full buffer is fine: the slot written is the
  // one being popped, so the count is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_ent;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_record_reader.sv
// Read-side initiator for the single-port SRAM. On start it range-checks the
// request, then reads rec_count records of REC_WORDS words from base_addr and
// streams them with record/word framing. It never writes the SRAM.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : request pulse, sampled only in IDLE
//   base_addr, rec_count : request, latched with start
//   busy                 : CHECK/RUN/DRAIN
//   done                 : one-cycle pulse after the last word transfers
//   err                  : one-cycle pulse when the request exceeds the SRAM
//   dbg_state            : current FSM state
//   sram                 : SRAM read port (master side)
//   m                    : record word stream (master side)
module sram_record_reader
  import sram_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  rec_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output rd_state_e         dbg_state,
  sram_rd_if.master         sram,
  rec_stream_if.master      m
);

  rd_state_e        r_state;
  rd_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [TOT_W-1:0] r_words_left;
  logic             r_inflight;
  logic             r_err;
  logic [IDX_W-1:0] r_push_idx;
  logic [CNT_W-1:0] r_rec_left;

  logic             w_issue;
  logic             w_pop;
  logic             w_credit;
  logic             w_range_ok;
  logic             w_drained;
  logic             w_valid;
  logic             w_err_set;
  logic [1:0]       w_count;
  logic [2:0]       w_outstanding;
  logic             w_rec_end;
  skid_ent_t        w_push_ent;
  skid_ent_t        w_head;

  assign w_pop      = w_valid & m.m_ready;
  assign w_range_ok = range_ok(r_addr, r_cnt);

  // Words already committed (buffered or coming back from the SRAM) that will
  // still occupy the buffer after this cycle's pop. Issuing only below 2
  // keeps a 2-entry buffer from ever overflowing, whatever m_ready does.
  assign w_outstanding = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit      = (w_outstanding < 3'd2);

  // Buffer is empty at the end of this cycle and nothing is returning.
  assign w_drained = !r_inflight &&
                     ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

  assign w_err_set = (r_state == ST_CHECK) && (r_cnt != '0) && !w_range_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_cnt == '0)      w_next = ST_DONE;
        else if (!w_range_ok) w_next = ST_IDLE;
        else                  w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_words_left == TOT_W'(1)) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drained) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Framing is attached when the returning word is pushed, so it always
  // matches the word it describes regardless of downstream stalls.
  assign w_rec_end           = (r_push_idx == IDX_W'(REC_WORDS - 1));
  assign w_push_ent.data     = sram.sram_rdata;
  assign w_push_ent.idx      = r_push_idx;
  assign w_push_ent.first    = (r_push_idx == '0);
  assign w_push_ent.last     = w_rec_end;
  assign w_push_ent.rec_last = w_rec_end && (r_rec_left == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_words_left <= '0;
      r_inflight   <= 1'b0;
      r_err        <= 1'b0;
      r_push_idx   <= '0;
      r_rec_left   <= '0;
    end else begin
      r_inflight <= w_issue;
      r_err      <= w_err_set;
      if ((r_state == ST_IDLE) && start) begin
        r_addr       <= base_addr;
        r_cnt        <= rec_count;
        r_words_left <= total_words(rec_count);
        r_push_idx   <= '0;
        r_rec_left   <= rec_count;
      end
      if (w_issue) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_words_left <= r_words_left - TOT_W'(1);
      end
      if (r_inflight) begin
        if (w_rec_end) begin
          r_push_idx <= '0;
          r_rec_left <= r_rec_left - CNT_W'(1);
        end else begin
          r_push_idx <= r_push_idx + IDX_W'(1);
        end
      end
    end
  end

  sram_rd_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_ent   (w_push_ent),
    .i_ready (m.m_ready),
    .o_valid (w_valid),
    .o_ent   (w_head),
    .o_count (w_count)
  );

  assign sram.sram_cen_n = ~w_issue;
  assign sram.sram_wen   = 1'b0;
  assign sram.sram_addr  = r_addr;

  assign m.m_valid    = w_valid;
  assign m.m_data     = w_head.data;
  assign m.m_word_idx = w_head.idx;
  assign m.m_first    = w_head.first;
  assign m.m_last     = w_head.last;
  assign m.m_rec_last = w_head.rec_last;

  assign busy      = (r_state == ST_CHECK) || (r_state == ST_RUN) ||
                     (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_record_reader.sv
// Bench for sram_record_reader: SRAM array model, per-request expected
// word/address queues built from the record layout, one monitor that checks
// every SRAM access and every stream transfer, and directed plus random
// requests under several m_ready patterns.
module tb_sram_record_reader;
  import sram_reader_pkg::*;

  localparam int EW = DATA_W + IDX_W + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  rec_count;
  logic              busy;
  logic              done;
  logic              err;
  rd_state_e         dbg_state;

  sram_rd_if    u_sram ();
  rec_stream_if u_m ();

  sram_record_reader u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .rec_count (rec_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state),
    .sram      (u_sram),
    .m         (u_m)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  word_t mem [DEPTH];

  // SRAM: data_out valid the cycle after an enabled access.
  initial begin
    u_sram.sram_rdata = '0;
    forever begin
      @(posedge clk);
      if (!u_sram.sram_cen_n) u_sram.sram_rdata <= mem[u_sram.sram_addr];
    end
  end

  // m_ready patterns: 0 always high, 1 repeating 1,0,0,1, 2 random, 3 low.
  int ready_mode  = 3;
  int ready_phase = 0;
  initial begin
    u_m.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: u_m.m_ready = 1'b1;
        1: begin
          u_m.m_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
          ready_phase++;
        end
        2: u_m.m_ready = ($urandom_range(0, 3) != 0);
        default: u_m.m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [EW-1:0]     cap_q[$];

  int tests = 0;
  int fails = 0;
  int start_cyc;
  int issued_seq, popped_seq, valid_seen, blocked_seq;
  int first_issue_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] pack_ent(input word_t d, input int idx,
                                             input bit f, input bit l,
                                             input bit rl);
    return {d, IDX_W'(idx), f, l, rl};
  endfunction

  logic [EW-1:0] head;
  assign head = {u_m.m_data, u_m.m_word_idx, u_m.m_first, u_m.m_last,
                 u_m.m_rec_last};

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_ent;
  int            mon_pop;
  int            mon_outb;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      mon_pop  = (u_m.m_valid && u_m.m_ready) ? 1 : 0;
      mon_outb = issued_seq - popped_seq;
      if (u_m.m_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) chk("hold", 128'({u_m.m_valid, head}), 128'({1'b1, prev_ent}));
      if (!u_sram.sram_cen_n) begin
        chk("credit_ok", 128'((mon_outb - mon_pop) < 2), 128'(1));
        chk("wen_low", 128'(u_sram.sram_wen), 128'(0));
        chk("read_expected", 128'(exp_addr_q.size() != 0), 128'(1));
        if (exp_addr_q.size() != 0)
          chk("read_addr", 128'(u_sram.sram_addr), 128'(exp_addr_q.pop_front()));
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        issued_seq++;
      end else if ((mon_outb - mon_pop) >= 2) begin
        blocked_seq++;
      end
      if (mon_pop != 0) begin
        chk("word_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) chk("word", 128'(head), 128'(exp_q.pop_front()));
        cap_q.push_back(head);
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        popped_seq++;
      end
      prev_stall = u_m.m_valid && !u_m.m_ready;
      prev_ent   = head;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_seq();
    exp_q.delete();
    exp_addr_q.delete();
    cap_q.delete();
    issued_seq = 0; popped_seq = 0; valid_seen = 0; blocked_seq = 0;
    first_issue_cyc = -1; first_valid_cyc = -1;
    first_hs_cyc = -1; last_hs_cyc = -1;
  endtask

  // Expected reads and words straight from the record layout.
  task automatic build_model(input int base, input int cnt);
    int a;
    clear_seq();
    for (int r = 0; r < cnt; r++) begin
      for (int w = 0; w < REC_WORDS; w++) begin
        a = base + r * REC_WORDS + w;
        exp_addr_q.push_back(ADDR_W'(a));
        exp_q.push_back(pack_ent(mem[a], w, w == 0, w == REC_WORDS - 1,
                                 (w == REC_WORDS - 1) && (r == cnt - 1)));
      end
    end
  endtask

  task automatic kick(input int base, input int cnt);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    rec_count = CNT_W'(cnt);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    rec_count = CNT_W'($urandom);
  endtask

  task automatic run_seq(input int base, input int cnt, input int mode,
                         input bit inject);
    bit exp_err, got_done, got_err;
    int end_cyc;
    exp_err = (cnt != 0) && (base + cnt * REC_WORDS > DEPTH);
    if (exp_err) build_model(base, 0);
    else         build_model(base, cnt);
    ready_mode  = mode;
    ready_phase = 0;
    kick(base, cnt);
    got_done = 1'b0; got_err = 1'b0; end_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", 128'(busy), 128'(1));
      if (inject && i == 5) begin
        start = 1'b1; base_addr = 7'd5; rec_count = 7'd3;
      end else if (inject && i == 6) begin
        start = 1'b0;
      end
      if (done || err) begin
        got_done = done; got_err = err; end_cyc = cyc;
        break;
      end
    end
    if (!got_done && !got_err) chk("seq_timeout", 128'(end_cyc), 128'(0));
    if (exp_err) begin
      chk("err_seen", 128'(got_err), 128'(1));
      chk("done_absent", 128'(got_done), 128'(0));
      @(negedge clk);
      chk("err_single", 128'(err), 128'(0));
      chk("busy_after_err", 128'(busy), 128'(0));
      chk("err_no_reads", 128'(issued_seq), 128'(0));
      chk("err_no_valid", 128'(valid_seen), 128'(0));
    end else begin
      chk("done_seen", 128'(got_done), 128'(1));
      chk("err_absent", 128'(got_err), 128'(0));
      @(negedge clk);
      chk("done_single", 128'(done), 128'(0));
      chk("busy_idle", 128'(busy), 128'(0));
      chk("words_issued", 128'(issued_seq), 128'(cnt * REC_WORDS));
      chk("words_popped", 128'(popped_seq), 128'(cnt * REC_WORDS));
      chk("words_left", 128'(exp_q.size()), 128'(0));
      if (cnt == 0) begin
        chk("zero_done_lat", 128'(end_cyc - start_cyc), 128'(2));
      end else begin
        chk("done_lat", 128'(end_cyc - last_hs_cyc), 128'(1));
        chk("first_issue_lat", 128'(first_issue_cyc - start_cyc), 128'(2));
        chk("first_valid_lat", 128'(first_valid_cyc - first_issue_cyc), 128'(2));
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},   128'(busy), 128'(0));
    chk({tag, "_done"},   128'(done), 128'(0));
    chk({tag, "_err"},    128'(err), 128'(0));
    chk({tag, "_cen_n"},  128'(u_sram.sram_cen_n), 128'(1));
    chk({tag, "_wen"},    128'(u_sram.sram_wen), 128'(0));
    chk({tag, "_addr"},   128'(u_sram.sram_addr), 128'(0));
    chk({tag, "_valid"},  128'(u_m.m_valid), 128'(0));
    chk({tag, "_fields"}, 128'(head), 128'(0));
    chk({tag, "_state"},  128'(dbg_state), 128'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  rec_hdr_t hdr;
  int       rb, rc;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    rec_count = '0;
    clear_seq();
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    mem[21] = 64'h3800380038000000;
    mem[80] = 64'h07aaaaaaaaaaaaaa;
    mem[61] = 64'hc900c40034000000;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic stream with literal anchors.
    run_seq(21, 6, 0, 1'b0);
    chk("basic_count", 128'(cap_q.size()), 128'(60));
    if (cap_q.size() == 60) begin
      chk("basic_hdr_data", 128'(cap_q[0][EW-1:7]), 128'(64'h3800380038000000));
      chk("basic_hdr_flags", 128'(cap_q[0][6:0]), 128'(7'b0000_100));
      hdr = rec_hdr_t'(cap_q[0][EW-1:7]);
      chk("basic_hdr_x", 128'(hdr.x), 128'(16'h3800));
      chk("basic_hdr_rsvd", 128'(hdr.rsvd), 128'(0));
      chk("basic_addr30_last", 128'(cap_q[9][1]), 128'(1));
      chk("basic_addr31_first", 128'(cap_q[10][2]), 128'(1));
      chk("basic_addr80_data", 128'(cap_q[59][EW-1:7]), 128'(64'h07aaaaaaaaaaaaaa));
      chk("basic_addr80_rec_last", 128'(cap_q[59][0]), 128'(1));
      chk("basic_rate", 128'(last_hs_cyc - first_hs_cyc), 128'(59));
    end

    // Backpressure 1,0,0,1.
    run_seq(41, 2, 1, 1'b0);
    chk("bp_credit_blocked", 128'(blocked_seq > 0), 128'(1));

    // Range errors, including one that only a full-width total catches.
    run_seq(120, 1, 0, 1'b0);
    run_seq(0, 127, 0, 1'b0);
    run_seq(9, 12, 0, 1'b0);
    // Exactly fills the SRAM.
    run_seq(8, 12, 0, 1'b0);

    // Zero records.
    run_seq(7, 0, 0, 1'b0);

    // Start during RUN is ignored.
    run_seq(3, 3, 0, 1'b1);

    // Asynchronous reset while the buffer is full.
    build_model(41, 2);
    ready_mode = 3;
    kick(41, 2);
    repeat (8) @(negedge clk);
    chk("mid_busy", 128'(busy), 128'(1));
    chk("mid_valid", 128'(u_m.m_valid), 128'(1));
    chk("mid_outstanding", 128'(issued_seq - popped_seq), 128'(2));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    clear_seq();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_seq(61, 2, 0, 1'b0);
    chk("post_rst_count", 128'(cap_q.size()), 128'(20));
    if (cap_q.size() == 20) begin
      chk("post_rst_hdr", 128'(cap_q[0][EW-1:7]), 128'(64'hc900c40034000000));
      chk("post_rst_first", 128'(cap_q[0][2]), 128'(1));
    end

    // Random legal requests with random m_ready, then a random illegal one.
    for (int k = 0; k < 4; k++) begin
      rc = $urandom_range(1, 6);
      rb = $urandom_range(0, DEPTH - rc * REC_WORDS);
      run_seq(rb, rc, 2, 1'b0);
    end
    rc = $urandom_range(2, 5);
    rb = $urandom_range(DEPTH - rc * REC_WORDS + 1, DEPTH - 1);
    run_seq(rb, rc, 2, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_record_reader.md
Name: sram_record_reader

Overview:
- Read-side initiator for the single-port shield SRAM: cen_n active-low enable, wen active-high write, addr, 64-bit data_out valid one cycle after an enabled access.
- On a start pulse, fetches rec_count fixed-size records of REC_WORDS 64-bit words, starting at base_addr. Each record is one packed-FP16 header word followed by payload words.
- Streams the words to the downstream compute pipeline over a valid/ready interface, with record and word framing.
- Never writes the SRAM.

Parameters:
- DATA_W, 64, SRAM word width (4 x FP16).
- ADDR_W, 7, SRAM address width.
- DEPTH, 128, SRAM words; legal addresses are 0..DEPTH-1.
- REC_WORDS, 10, words per record.
- CNT_W, 7, width of rec_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  address of first record header; sampled with start.
- rec_count  in  CNT_W  number of records; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  one-cycle pulse after the last word handshakes downstream.
- err  out  1  one-cycle pulse on range violation; no reads issued.
- sram_cen_n  out  1  SRAM enable, active low.
- sram_wen  out  1  tied 0.
- sram_addr  out  ADDR_W  SRAM address.
- sram_rdata  in  DATA_W  SRAM data_out.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  word.
- m_word_idx  out  4  index within record, 0..REC_WORDS-1.
- m_first  out  1  m_word_idx==0 (header word).
- m_last  out  1  last word of record.
- m_rec_last  out  1  last word of last record.

Behaviour:
- Reset values (async): busy=0, done=0, err=0, sram_cen_n=1, sram_wen=0, sram_addr=0, m_valid=0, all stream fields 0, FSM=IDLE, FIFO empty, inflight=0.
- FSM states: IDLE, CHECK, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and rec_count, then goes to CHECK.
  - start is ignored in every other state.
- CHECK (1 cycle):
  - total = rec_count*REC_WORDS, computed at ADDR_W+CNT_W bits (no truncation).
  - rec_count==0: go to DONE; done pulses with no SRAM access.
  - base_addr+total > DEPTH: err pulses, return to IDLE, sram_cen_n stays 1.
  - Otherwise go to RUN.
- RUN:
  - Issues a read (sram_cen_n=0, sram_addr=next) when credit allows.
  - Credit rule: fifo_count + inflight - pop < 2, where pop = m_valid & m_ready that cycle.
  - inflight is 1 for the cycle after an issue. sram_rdata is pushed into the FIFO in that cycle.
  - Addresses increment by 1. No wrap is possible; CHECK guarantees this.
  - After the final issue, go to DRAIN.
- DRAIN: waits for the FIFO to empty and inflight=0, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Output buffer:
  - 2-entry FIFO; m_data and flags come from the head entry.
  - m_valid is held and fields are stable until m_ready.
  - Sustains 1 word/clock with m_ready held high.
  - First m_valid appears 2 cycles after the first issue (issue, SRAM latency, FIFO register).
- Framing:
  - word_idx counter wraps REC_WORDS-1 to 0 at push; m_last when idx==REC_WORDS-1.
  - Record counter decrements at each record end; m_rec_last on the final word.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- m_ready low never drops data: the credit rule blocks issue, so nothing is read that cannot be buffered.
- sram_cen_n is high in every cycle without an issue.
- Reset mid-operation: everything returns to reset values immediately. Partial data is discarded and no done pulse is produced.

Decomposition:
- Package sram_reader_pkg holds:
  - DATA_W, ADDR_W, DEPTH, REC_WORDS.
  - typedef word_t.
  - typedef fp16_t.
  - packed struct rec_hdr_t with fields x, y, z (fp16_t) and rsvd (16b), msb first, for consumers decoding m_first words.
  - enum rd_state_e.
- Sub-module sram_rd_skid: 2-entry valid/ready FIFO carrying {data, idx, first, last, rec_last}, with count output used for credit.

Test Plan:
- Basic stream:
  - Stimulus: preload SRAM model; start, base_addr=21, rec_count=6, m_ready=1.
  - Response: 60 words, addresses 21..80 each read exactly once, in order.
  - First word 64'h3800380038000000 with m_first=1, idx=0.
  - Word at addr 30 has m_last=1; addr 80 word 64'h7aaaaaaaaaaaaaa has m_rec_last=1.
  - done one cycle after the last handshake.
- Backpressure:
  - Stimulus: base 41, rec_count 2; m_ready toggles 1,0,0,1 repeating.
  - Response: 20 words in exact address order, none duplicated or lost.
  - Never more than 2 outstanding (FIFO count + inflight).
  - sram_cen_n=1 while credit is exhausted.
- Range error:
  - Stimulus: base 120, rec_count 1 (120+10=130>128).
  - Response: err pulse; sram_cen_n never low; m_valid never high; busy returns to 0.
- Zero count:
  - Stimulus: rec_count=0.
  - Response: done pulse 2 cycles after start; no SRAM access.
- Ignored start:
  - Stimulus: start pulsed again during RUN with a different base.
  - Response: ignored; the original sequence completes unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (mid-cycle) during RUN with the FIFO full.
  - Response: outputs reach reset values before the next clock edge; a fresh start with base 61 streams correctly from 64'hc900c40034000000.
